// File: rtl/spi_config_regs.sv
// Addressed SPI configuration register file in the system clock domain.
// Writes collect in staging and commit atomically when CSn rises; supports burst writes and read-back.
`timescale 1ns/1ps
module spi_config_regs #(
   parameter int                NREG    = 4,
   parameter int                W       = 8,
   parameter logic [NREG*W-1:0] RST_VAL = '0,
   parameter int                SYNC    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_clk,
   input  logic              spi_csn,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [NREG*W-1:0] cfg,
   output logic              cfg_update,
   output logic              frame_err
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_COMMIT} state_t;

   logic [SYNC-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
   logic            sck_prev_q, csn_prev_q, armed_q;
   logic            sck_s, csn_s, mosi_s;
   logic            sck_rise, sck_fall, csn_rise, csn_fall;

   state_t          state_q, state_d;
   logic [6:0]      cmd_q, cmd_d;
   logic [2:0]      cmd_cnt_q, cmd_cnt_d;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [6:0]      addr_q, addr_d, nxt_addr, rd_addr;
   logic [W-1:0]    sh_q, sh_d, word_in, rd_val;
   logic            miso_q, miso_d;
   logic [NREG-1:0] pending_q, pending_d;
   logic [W-1:0]    stg_q [NREG];
   logic [W-1:0]    stg_d [NREG];
   logic [W-1:0]    cfg_q [NREG];
   logic [W-1:0]    cfg_d [NREG];
   logic            bad_addr_q, bad_addr_d, mode_err_q, mode_err_d;
   logic            skip_q, skip_d, err_q, err_d;
   logic            changed, hit;

   assign sck_s    = sck_sync_q[SYNC-1];
   assign csn_s    = csn_sync_q[SYNC-1];
   assign mosi_s   = mosi_sync_q[SYNC-1];
   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   assign csn_rise = csn_s & ~csn_prev_q;
   assign csn_fall = ~csn_s & csn_prev_q;

   // CSn chain resets low, so a CSn held low across reset must rise before any fall can start a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         csn_sync_q  <= '0;
         mosi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         csn_prev_q  <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         sck_sync_q  <= {sck_sync_q[SYNC-2:0], spi_clk};
         csn_sync_q  <= {csn_sync_q[SYNC-2:0], spi_csn};
         mosi_sync_q <= {mosi_sync_q[SYNC-2:0], spi_mosi};
         sck_prev_q  <= sck_s;
         csn_prev_q  <= csn_s;
         armed_q     <= armed_q | csn_s;
      end
   end

   assign nxt_addr = (addr_q == 7'(NREG-1)) ? 7'd0 : addr_q + 7'd1;

   always_comb begin
      rd_addr = (state_q == S_CMD) ? {cmd_q[5:0], mosi_s} : nxt_addr;
      rd_val  = '0;
      for (int i = 0; i < NREG; i++) begin
         if (rd_addr == 7'(i)) rd_val = cfg_q[i];
      end
   end

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cmd_d      = cmd_q;
      cmd_cnt_d  = cmd_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      addr_d     = addr_q;
      sh_d       = sh_q;
      miso_d     = miso_q;
      pending_d  = pending_q;
      stg_d      = stg_q;
      cfg_d      = cfg_q;
      bad_addr_d = bad_addr_q;
      mode_err_d = mode_err_q;
      skip_d     = skip_q;
      err_d      = err_q;
      changed    = 1'b0;
      hit        = 1'b0;
      cfg_update = 1'b0;
      frame_err  = 1'b0;
      word_in    = {sh_q[W-2:0], mosi_s};
      case (state_q)
         S_IDLE: begin
            if (csn_fall) begin
               state_d    = S_CMD;
               cmd_d      = '0;
               cmd_cnt_d  = '0;
               bit_cnt_d  = '0;
               addr_d     = '0;
               sh_d       = '0;
               miso_d     = 1'b0;
               pending_d  = '0;
               stg_d      = cfg_q;
               bad_addr_d = 1'b0;
               err_d      = 1'b0;
               mode_err_d = sck_s;
               skip_d     = sck_s;
            end
         end
         S_CMD: begin
            if (sck_rise) begin
               if (skip_q) begin
                  skip_d = 1'b0;
               end else begin
                  cmd_d     = {cmd_q[5:0], mosi_s};
                  cmd_cnt_d = cmd_cnt_q + 3'd1;
                  if (cmd_cnt_q == 3'd7) begin
                     addr_d    = {cmd_q[5:0], mosi_s};
                     bit_cnt_d = '0;
                     state_d   = cmd_q[6] ? S_RDATA : S_WDATA;
                     sh_d      = cmd_q[6] ? rd_val : '0;
                  end
               end
            end
         end
         S_WDATA: begin
            if (sck_rise) begin
               sh_d      = word_in;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(W-1)) begin
                  bit_cnt_d = '0;
                  for (int i = 0; i < NREG; i++) begin
                     if (addr_q == 7'(i)) begin
                        stg_d[i]     = word_in;
                        pending_d[i] = 1'b1;
                        hit          = 1'b1;
                     end
                  end
                  if (!hit) bad_addr_d = 1'b1;
                  addr_d = nxt_addr;
               end
            end
         end
         S_RDATA: begin
            if (sck_fall) begin
               miso_d    = sh_q[W-1];
               sh_d      = sh_q << 1;
               bit_cnt_d = bit_cnt_q + 5'd1;
               if (bit_cnt_q == 5'(W-1)) begin
                  bit_cnt_d = '0;
                  addr_d    = nxt_addr;
                  sh_d      = rd_val;
               end
            end
         end
         S_COMMIT: begin
            for (int i = 0; i < NREG; i++) begin
               if (pending_q[i]) begin
                  cfg_d[i] = stg_q[i];
                  if (stg_q[i] != cfg_q[i]) changed = 1'b1;
               end
            end
            cfg_update = changed;
            frame_err  = err_q;
            pending_d  = '0;
            bad_addr_d = 1'b0;
            mode_err_d = 1'b0;
            skip_d     = 1'b0;
            miso_d     = 1'b0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (csn_rise && state_q != S_COMMIT) begin
         state_d = S_COMMIT;
         err_d   = (state_q != S_IDLE) &&
                   (mode_err_q || bad_addr_q ||
                    (state_q == S_CMD && cmd_cnt_q != 3'd0) ||
                    (state_q == S_WDATA && bit_cnt_q != 5'd0));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         cmd_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         addr_q     <= '0;
         sh_q       <= '0;
         miso_q     <= 1'b0;
         pending_q  <= '0;
         bad_addr_q <= 1'b0;
         mode_err_q <= 1'b0;
         skip_q     <= 1'b0;
         err_q      <= 1'b0;
         // NOTE: the register file is flops, not RAM, so it is reset to its defaults like any other state.
         for (int i = 0; i < NREG; i++) begin
            cfg_q[i] <= RST_VAL[i*W +: W];
            stg_q[i] <= RST_VAL[i*W +: W];
         end
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         cmd_cnt_q  <= cmd_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         addr_q     <= addr_d;
         sh_q       <= sh_d;
         miso_q     <= miso_d;
         pending_q  <= pending_d;
         bad_addr_q <= bad_addr_d;
         mode_err_q <= mode_err_d;
         skip_q     <= skip_d;
         err_q      <= err_d;
         cfg_q      <= cfg_d;
         stg_q      <= stg_d;
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cfg
      assign cfg[g*W +: W] = cfg_q[g];
   end

   assign spi_miso    = miso_q;
   assign spi_miso_oe = armed_q & ~csn_s;

endmodule

// File: tb/tb_spi_config_regs.sv
// Scoreboard bench for spi_config_regs (NREG=4, W=8, SYNC=2): a byte model predicts commits,
// pulses and read-back; predictions are queued at stimulus time and popped as the DUT responds.
`timescale 1ns/1ps
module tb_spi_config_regs;
   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        spi_clk = 1'b0;
   logic        spi_csn = 1'b1;
   logic        spi_mosi = 1'b0;
   logic        spi_miso, spi_miso_oe, cfg_update, frame_err;
   logic [31:0] cfg;

   spi_config_regs #(.NREG(4), .W(8), .RST_VAL('0), .SYNC(2)) dut (
      .clk(clk), .rst_n(rst_n), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .cfg(cfg),
      .cfg_update(cfg_update), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  m_cfg [4];
   int          n_tests = 0;
   int          n_fail = 0;
   int          upd_cnt = 0;
   int          err_cnt = 0;
   int          upd0, err0;

   always @(negedge clk) begin
      if (cfg_update) upd_cnt++;
      if (frame_err)  err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] got);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, got, e.val);
      end
   endtask

   function automatic logic [31:0] flat();
      return {m_cfg[3], m_cfg[2], m_cfg[1], m_cfg[0]};
   endfunction

   task automatic push_commit(input bit chg, input bit bad);
      sb_push("cfg", flat());
      sb_push("cfg_update_cnt", 32'(chg));
      sb_push("frame_err_cnt", 32'(bad));
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      upd0 = upd_cnt;
      err0 = err_cnt;
      spi_csn = 1'b0;
      wait_clk(4);
   endtask

   task automatic spi_bits(input logic [47:0] bits, input int n, output logic [47:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         spi_mosi = bits[i];
         wait_clk(HALF);
         rx = {rx[46:0], spi_miso};
         spi_clk = 1'b1;
         wait_clk(HALF);
         spi_clk = 1'b0;
      end
      spi_mosi = 1'b0;
   endtask

   task automatic end_frame(input bit timed, input logic [31:0] pre, input logic [31:0] post);
      wait_clk(HALF);
      spi_csn = 1'b1;
      if (timed) begin
         repeat (3) @(posedge clk);
         #1 check("cfg_before_commit_edge", cfg, pre);
         @(posedge clk);
         #1 check("cfg_at_sync_plus_2", cfg, post);
      end
      wait_clk(12);
      sb_pop(cfg);
      sb_pop(32'(upd_cnt - upd0));
      sb_pop(32'(err_cnt - err0));
   endtask

   task automatic do_write(input logic [7:0] cmd, input logic [31:0] data, input int nwords,
                           input int extra, input bit timed);
      logic [7:0]  stg [4];
      logic [3:0]  wr;
      logic [47:0] bits, rx, tmp;
      logic [31:0] pre;
      bit          chg, bad;
      int          a;
      stg = m_cfg;
      wr  = '0;
      chg = 1'b0;
      bad = (extra != 0);
      a   = int'(cmd[6:0]);
      bits = 48'(cmd);
      for (int w = 0; w < nwords; w++) begin
         tmp  = 48'(data >> (8 * (nwords - 1 - w)));
         bits = (bits << 8) | 48'(tmp[7:0]);
         if (a < 4) begin
            stg[a] = tmp[7:0];
            wr[a]  = 1'b1;
         end else begin
            bad = 1'b1;
         end
         a = (a == 3) ? 0 : (a + 1) % 128;
      end
      bits = (bits << extra) | (48'h15 & ((48'd1 << extra) - 48'd1));
      for (int i = 0; i < 4; i++) if (wr[i] && stg[i] != m_cfg[i]) chg = 1'b1;
      pre   = flat();
      m_cfg = stg;
      sb_push("wr_cmd_miso", 32'd0);
      push_commit(chg, bad);
      cs_low();
      spi_bits(bits, 8 + 8 * nwords + extra, rx);
      tmp = rx >> (8 * nwords + extra);
      sb_pop(32'(tmp[7:0]));
      end_frame(timed, pre, flat());
   endtask

   task automatic do_read(input logic [7:0] cmd, input int nbytes);
      logic [47:0] rx, tmp;
      int          a;
      a = int'(cmd[6:0]);
      sb_push("rd_cmd_miso", 32'd0);
      for (int k = 0; k < nbytes; k++) begin
         sb_push($sformatf("rd_byte%0d", k), (a < 4) ? 32'(m_cfg[a]) : 32'd0);
         a = (a == 3) ? 0 : (a + 1) % 128;
      end
      push_commit(1'b0, 1'b0);
      cs_low();
      check("miso_oe_in_frame", 32'(spi_miso_oe), 32'd1);
      spi_bits(48'(cmd) << (8 * nbytes), 8 + 8 * nbytes, rx);
      tmp = rx >> (8 * nbytes);
      sb_pop(32'(tmp[7:0]));
      for (int k = 0; k < nbytes; k++) begin
         tmp = rx >> (8 * (nbytes - 1 - k));
         sb_pop(32'(tmp[7:0]));
      end
      end_frame(1'b0, 32'd0, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] rx;
      for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;

      // Reset state and a long quiet interval.
      wait_clk(5);
      check("rst_cfg", cfg, flat());
      check("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
      check("rst_miso", 32'(spi_miso), 32'd0);
      rst_n = 1'b1;
      wait_clk(1000);
      check("idle_update_pulses", 32'(upd_cnt), 32'd0);
      check("idle_err_pulses", 32'(err_cnt), 32'd0);
      check("idle_cfg", cfg, flat());
      check("idle_miso_oe", 32'(spi_miso_oe), 32'd0);

      // Single write with commit-latency check, then burst write wrapping 3 -> 0.
      do_write(8'h01, 32'h0000_00A5, 1, 0, 1'b1);
      do_write(8'h03, 32'h0000_1122, 2, 0, 1'b0);

      // Read-back burst, then a rewrite of an identical value (commit without change).
      do_read(8'h81, 2);
      do_write(8'h01, 32'h0000_00A5, 1, 0, 1'b0);

      // Partial word, out-of-range address, and a complete word followed by a partial one.
      do_write(8'h02, 32'h0, 0, 5, 1'b0);
      do_write(8'h05, 32'h0000_0077, 1, 0, 1'b0);
      do_write(8'h02, 32'h0000_005A, 1, 3, 1'b0);
      do_read(8'h83, 2);

      // Frame with no SCK edges: no commit, no pulse.
      push_commit(1'b0, 1'b0);
      cs_low();
      end_frame(1'b0, 32'd0, 32'd0);

      // Incomplete command (3 bits).
      push_commit(1'b0, 1'b1);
      cs_low();
      spi_bits(48'h5, 3, rx);
      end_frame(1'b0, 32'd0, 32'd0);

      // CSn falls with SCK high: first rise is lost and the frame is malformed.
      push_commit(1'b0, 1'b1);
      spi_clk = 1'b1;
      wait_clk(HALF);
      cs_low();
      wait_clk(4);
      spi_clk = 1'b0;
      wait_clk(HALF);
      spi_bits({32'd0, 8'h01, 8'h5A}, 16, rx);
      end_frame(1'b0, 32'd0, 32'd0);

      // Reset mid-word of a write burst, release with CSn still low, then a clean write.
      cs_low();
      spi_bits(48'h00A, 12, rx);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midframe_rst_cfg", cfg, 32'd0);
      check("midframe_rst_miso_oe", 32'(spi_miso_oe), 32'd0);
      for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(20);
      push_commit(1'b0, 1'b0);
      end_frame(1'b0, 32'd0, 32'd0);
      wait_clk(20);
      do_write(8'h00, 32'h0000_003C, 1, 0, 1'b0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
